rgb_frame_capture: RTL and testbench

- Parametrised successor of the RGB parallel-video front end. Samples the 24-bit RGB bus with hsync/vsync on the pixel clock, frames the stream, and emits each pixel with its linear index and µblock coordinates.
- The µblock geometry and the grid of µblocks are generic.
- Adds a frame-level state machine, a per-frame enable latch, a frame-done strobe and a captured-frame counter.
- Sits between the RGB input pins and the pixel/framebuffer writer.

---
 rtl/rgb_frame_capture.sv | 147 ++++++++++++++
 tb/tb_rgb_frame_capture.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rgb_frame_capture.sv
// rgb_frame_capture: frames the RGB video bus and tags each pixel with its index and µblock coordinates; define RGB_FRAME_CHECK_EN to add line/frame geometry checking
module rgb_frame_capture #(
    parameter int DATA_W    = 24,
    parameter int PIX_COLS  = 8,
    parameter int PIX_LINES = 16,
    parameter int BLK_COLS  = 5,
    parameter int BLK_LINES = 4,
    parameter int IDX_W     = 32,
    parameter int FCNT_W    = 16,
    parameter int PC_W      = (PIX_COLS  > 1) ? $clog2(PIX_COLS)  : 1,
    parameter int PL_W      = (PIX_LINES > 1) ? $clog2(PIX_LINES) : 1,
    parameter int BC_W      = (BLK_COLS  > 1) ? $clog2(BLK_COLS)  : 1,
    parameter int BL_W      = (BLK_LINES > 1) ? $clog2(BLK_LINES) : 1
) (
    input  logic              rgb_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rgb,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              rgb_enable,
    output logic [DATA_W-1:0] pixel_data,
    output logic [IDX_W-1:0]  pixel_idx,
    output logic              pixel_valid,
    output logic [PC_W-1:0]   pixel_col,
    output logic [PL_W-1:0]   pixel_line,
    output logic [BC_W-1:0]   block_col,
    output logic [BL_W-1:0]   block_line,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count,
    output logic              line_err,
    output logic              frame_err
);
    typedef enum logic [1:0] {WAIT_FRAME, CAPTURE, DISCARD} state_t;
    state_t state, state_n;
    logic vsync_r, start, stop, act, valid_c, done_c, err_seen;
    logic [PC_W-1:0] pc_q, pc_c;
    logic [PL_W-1:0] pl_q, pl_c;
    logic [BC_W-1:0] bc_q, bc_c;
    logic [BL_W-1:0] bl_q, bl_c;
    logic [IDX_W-1:0] idx_q, idx_c;
    logic pc_end, bc_end, pl_end, bl_end;
    assign start = vsync & ~vsync_r;
    assign stop  = ~vsync & vsync_r;
    assign act   = vsync & hsync;
    // next-state: the enable decision is taken once, at frame start
    always_comb begin
        state_n = state;
        if (state == WAIT_FRAME && start) state_n = rgb_enable ? CAPTURE : DISCARD;
        else if (state != WAIT_FRAME && stop) state_n = WAIT_FRAME;
    end
    // coordinate of the current pixel: a start cycle forces everything back to the origin
    always_comb begin
        pc_c   = start ? '0 : pc_q;
        bc_c   = start ? '0 : bc_q;
        pl_c   = start ? '0 : pl_q;
        bl_c   = start ? '0 : bl_q;
        idx_c  = start ? '0 : idx_q;
        pc_end = pc_c == PC_W'(PIX_COLS - 1);
        bc_end = bc_c == BC_W'(BLK_COLS - 1);
        pl_end = pl_c == PL_W'(PIX_LINES - 1);
        bl_end = bl_c == BL_W'(BLK_LINES - 1);
        valid_c = act & (state == CAPTURE || state_n == CAPTURE) & ~err_seen;
        done_c  = (state == CAPTURE) & stop;
    end
    // frame state and vsync edge history
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            state   <= WAIT_FRAME;
            vsync_r <= 1'b0;
        end else begin
            state   <= state_n;
            vsync_r <= vsync;
        end
    end
    // next-pixel counters with the column -> block column -> line -> block line carry chain
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            bc_q  <= '0;
            pl_q  <= '0;
            bl_q  <= '0;
            idx_q <= '0;
        end else begin
            idx_q <= act ? idx_c + IDX_W'(1) : idx_c;
            pc_q  <= act ? (pc_end ? '0 : pc_c + PC_W'(1)) : pc_c;
            bc_q  <= (act & pc_end) ? (bc_end ? '0 : bc_c + BC_W'(1)) : bc_c;
            pl_q  <= (act & pc_end & bc_end) ? (pl_end ? '0 : pl_c + PL_W'(1)) : pl_c;
            bl_q  <= (act & pc_end & bc_end & pl_end) ? (bl_end ? '0 : bl_c + BL_W'(1)) : bl_c;
        end
    end
    // output stage: one cycle behind the sampling edge, tags hold across invalid cycles
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_idx   <= '0;
            pixel_col   <= '0;
            block_col   <= '0;
            pixel_line  <= '0;
            block_line  <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            pixel_data  <= rgb;
            pixel_valid <= valid_c;
            if (valid_c) begin
                pixel_idx  <= idx_c;
                pixel_col  <= pc_c;
                block_col  <= bc_c;
                pixel_line <= pl_c;
                block_line <= bl_c;
            end
            frame_done <= done_c;
            if (done_c & ~err_seen) frame_count <= frame_count + FCNT_W'(1);
        end
    end
`ifdef RGB_FRAME_CHECK_EN
    localparam int LINE_PIX    = PIX_COLS * BLK_COLS;
    localparam int FRAME_LINES = PIX_LINES * BLK_LINES;
    logic hsync_r, line_end, line_bad;
    logic [IDX_W-1:0] run_cnt, line_cnt;
    assign line_end = hsync_r & ~hsync & vsync;
    assign line_bad = line_end & (run_cnt != IDX_W'(LINE_PIX));
    // geometry checker: pixels per hsync run and lines per frame
    always_ff @(posedge rgb_clk or posedge rst) begin
        if (rst) begin
            hsync_r   <= 1'b0;
            run_cnt   <= '0;
            line_cnt  <= '0;
            err_seen  <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            hsync_r   <= hsync;
            run_cnt   <= (start | line_end) ? IDX_W'(act) : run_cnt + IDX_W'(act);
            line_cnt  <= start ? '0 : line_cnt + IDX_W'(line_end);
            err_seen  <= start ? 1'b0 : err_seen | (line_bad & (state == CAPTURE));
            line_err  <= line_bad;
            frame_err <= stop & (state != WAIT_FRAME) & (line_cnt != IDX_W'(FRAME_LINES));
        end
    end
`else
    assign err_seen  = 1'b0;
    assign line_err  = 1'b0;
    assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_rgb_frame_capture.sv
// tb_rgb_frame_capture: directed checks of framing, indexing, enable latch, reset abort and a small geometry
module tb_rgb_frame_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, hsync, vsync, en;
    logic [23:0] rgb;
    logic [23:0] a_data;
    logic [31:0] a_idx;
    logic a_valid, a_done, a_le, a_fe;
    logic [2:0] a_pc, a_bc;
    logic [3:0] a_pl;
    logic [1:0] a_bl;
    logic [15:0] a_fc;
    logic [23:0] b_data;
    logic [31:0] b_idx;
    logic b_valid, b_done, b_le, b_fe;
    logic [1:0] b_pc, b_bc;
    logic [0:0] b_pl, b_bl;
    logic [15:0] b_fc;
    int n_chk = 0, n_fail = 0, a_cnt = 0;

    rgb_frame_capture dut_a (
        .rgb_clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .rgb_enable(en),
        .pixel_data(a_data), .pixel_idx(a_idx), .pixel_valid(a_valid), .pixel_col(a_pc),
        .pixel_line(a_pl), .block_col(a_bc), .block_line(a_bl), .frame_done(a_done),
        .frame_count(a_fc), .line_err(a_le), .frame_err(a_fe)
    );

    rgb_frame_capture #(.PIX_COLS(4), .PIX_LINES(2), .BLK_COLS(3), .BLK_LINES(2)) dut_b (
        .rgb_clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .rgb_enable(en),
        .pixel_data(b_data), .pixel_idx(b_idx), .pixel_valid(b_valid), .pixel_col(b_pc),
        .pixel_line(b_pl), .block_col(b_bc), .block_line(b_bl), .frame_done(b_done),
        .frame_count(b_fc), .line_err(b_le), .frame_err(b_fe)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic h, input logic [23:0] d);
        vsync = v;
        hsync = h;
        rgb = d;
        @(posedge clk);
        #1;
        if (a_valid) a_cnt++;
    endtask

    task automatic pix(input int k, input logic cap);
        int c, l;
        step(1'b1, 1'b1, 24'(k * 7 + 3));
        chk("valid", a_valid, cap);
        if (cap) begin
            c = k % 40;
            l = (k / 40) % 64;
            chk("idx", a_idx, k);
            chk("data", a_data, 24'(k * 7 + 3));
            chk("pcol", a_pc, c % 8);
            chk("bcol", a_bc, c / 8);
            chk("pline", a_pl, l % 16);
            chk("bline", a_bl, l / 16);
        end
    endtask

    task automatic frame(input int lines, input logic cap, input logic flip, input int exp_fc);
        int k = 0;
        a_cnt = 0;
        step(1'b1, 1'b0, 24'h0);
        chk("start_valid", a_valid, 1'b0);
        for (int l = 0; l < lines; l++) begin
            if (flip && l == 10) en = ~en;
            for (int p = 0; p < 40; p++) begin
                pix(k, cap);
                k++;
            end
            step(1'b1, 1'b0, 24'h0);
            step(1'b1, 1'b0, 24'h0);
        end
        step(1'b0, 1'b0, 24'h0);
        chk("done", a_done, cap);
        chk("count", a_fc, exp_fc);
        step(1'b0, 1'b0, 24'h0);
        chk("done_end", a_done, 1'b0);
        chk("nvalid", a_cnt, cap ? lines * 40 : 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; vsync = 1'b0; hsync = 1'b0; rgb = 24'h123456;
        #1;
        chk("reset_outs", {a_data, a_idx, a_valid, a_pc, a_bc, a_pl, a_bl, a_done, a_fc, a_le, a_fe}, 0);
        step(1'b0, 1'b0, 24'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 24'h0);
        chk("idle_valid", a_valid, 1'b0);
        frame(64, 1'b1, 1'b0, 1);
        en = 1'b0;
        frame(64, 1'b0, 1'b1, 1);
        chk("en_after_flip", en, 1'b1);
        frame(64, 1'b1, 1'b0, 2);
        step(1'b1, 1'b1, 24'hABCDEF);
        chk("same_edge_valid", a_valid, 1'b1);
        chk("same_edge_data", a_data, 24'hABCDEF);
        chk("same_edge_idx", a_idx, 0);
        chk("same_edge_coord", {a_pc, a_bc, a_pl, a_bl}, 0);
        step(1'b1, 1'b1, 24'h000001);
        chk("second_idx", a_idx, 1);
        chk("second_pcol", a_pc, 1);
        step(1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        chk("short_done", a_done, 1'b1);
        chk("short_count", a_fc, 3);
        step(1'b1, 1'b0, 24'h0);
        for (int k = 0; k < 1000; k++) pix(k, 1'b1);
        rst = 1'b1;
        #1;
        chk("midreset_outs", {a_data, a_idx, a_valid, a_pc, a_bc, a_pl, a_bl, a_done, a_fc, a_le, a_fe}, 0);
        step(1'b0, 1'b0, 24'h55AA55);
        chk("inreset_outs", {a_data, a_idx, a_valid, a_done, a_fc}, 0);
        rst = 1'b0;
        step(1'b0, 1'b1, 24'h0);
        chk("post_reset_valid", a_valid, 1'b0);
        chk("post_reset_count", a_fc, 0);
        frame(64, 1'b1, 1'b0, 1);
        step(1'b1, 1'b0, 24'h0);
        for (int k = 0; k < 49; k++) begin
            pix(k, 1'b1);
            if (k == 47) begin
                chk("small47_valid", b_valid, 1'b1);
                chk("small47_idx", b_idx, 47);
                chk("small47_coord", {b_pc, b_bc, b_pl, b_bl}, {2'd3, 2'd2, 1'b1, 1'b1});
            end
            if (k == 48) begin
                chk("small48_idx", b_idx, 48);
                chk("small48_coord", {b_pc, b_bc, b_pl, b_bl}, 0);
            end
        end
        step(1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 24'h0);
        chk("small_done", b_done, 1'b1);
        chk("small_count", b_fc, 2);
        chk("big_count", a_fc, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
